// File: rtl/uart_tx_prescaled.sv
// Serial transmitter with a per-frame prescale: start bit, 8 data bits LSB first,
// optional even/odd parity, one stop bit; all request fields captured at acceptance.
module uart_tx_prescaled (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] P_DATA,
   input  logic       Data_Valid,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic [5:0] Prescale,
   output logic       TX_OUT,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t     state;
   logic [5:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic [7:0] data_reg;
   logic       par_en_reg;
   logic       par_typ_reg;
   logic [5:0] prescale_reg;

   logic [5:0] eff_prescale;
   logic       bit_end;
   logic       parity_bit;
   logic [2:0] next_idx;

   // Prescale 0 and 1 cannot form a usable bit period, so both stretch to 2.
   assign eff_prescale = (Prescale < 6'd2) ? 6'd2 : Prescale;
   assign bit_end      = (edge_cnt == (prescale_reg - 6'd1));
   assign parity_bit   = (^data_reg) ^ par_typ_reg;
   assign next_idx     = bit_cnt[2:0] + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         edge_cnt     <= 6'd0;
         bit_cnt      <= 4'd0;
         data_reg     <= 8'd0;
         par_en_reg   <= 1'b0;
         par_typ_reg  <= 1'b0;
         prescale_reg <= 6'd0;
         TX_OUT       <= 1'b1;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               edge_cnt <= 6'd0;
               bit_cnt  <= 4'd0;
               TX_OUT   <= 1'b1;
               busy     <= 1'b0;
               if (Data_Valid) begin
                  data_reg     <= P_DATA;
                  par_en_reg   <= PAR_EN;
                  par_typ_reg  <= PAR_TYP;
                  prescale_reg <= eff_prescale;
                  state        <= START;
                  TX_OUT       <= 1'b0;
                  busy         <= 1'b1;
               end
            end

            START: begin
               if (bit_end) begin
                  edge_cnt <= 6'd0;
                  state    <= DATA;
                  TX_OUT   <= data_reg[0];
               end else begin
                  edge_cnt <= edge_cnt + 6'd1;
               end
            end

            // The line is loaded one bit ahead, so TX_OUT changes on the wrap edge.
            DATA: begin
               if (bit_end) begin
                  edge_cnt <= 6'd0;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     if (par_en_reg) begin
                        state  <= PARITY;
                        TX_OUT <= parity_bit;
                     end else begin
                        state  <= STOP;
                        TX_OUT <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 4'd1;
                     TX_OUT  <= data_reg[next_idx];
                  end
               end else begin
                  edge_cnt <= edge_cnt + 6'd1;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  edge_cnt <= 6'd0;
                  state    <= STOP;
                  TX_OUT   <= 1'b1;
               end else begin
                  edge_cnt <= edge_cnt + 6'd1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  edge_cnt <= 6'd0;
                  bit_cnt  <= 4'd0;
                  state    <= IDLE;
                  TX_OUT   <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  edge_cnt <= edge_cnt + 6'd1;
               end
            end

            default: begin
               state    <= IDLE;
               edge_cnt <= 6'd0;
               bit_cnt  <= 4'd0;
               TX_OUT   <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_prescaled.sv
// Scoreboard bench for uart_tx_prescaled: stimulus queues hand-computed frames,
// a monitor checks every bit period, the busy length and the idle gap after each frame.
module tb_uart_tx_prescaled;

   logic       clk;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [5:0] Prescale;
   logic       TX_OUT;
   logic       busy;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_bit;
      int         p;
      int         abort_at;
   } exp_t;

   exp_t exp_q[$];
   int   check_count = 0;
   int   pass_count  = 0;
   int   frames_done = 0;

   uart_tx_prescaled dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual == expected) pass_count++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Queue the expected frame and pulse Data_Valid for one cycle.
   task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                                input logic [5:0] ps, input int exp_p, input logic exp_par,
                                input int abort_at);
      exp_t e;
      @(negedge clk);
      e.data = d; e.par_en = pe; e.par_bit = exp_par; e.p = exp_p; e.abort_at = abort_at;
      exp_q.push_back(e);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
      @(negedge clk);
      Data_Valid = 1'b0;
   endtask

   task automatic waitFrames(input int n);
      int t = 0;
      while (frames_done < n && t < 5000) begin
         @(negedge clk);
         t++;
      end
      checkOutput($sformatf("frames_done_%0d", n), frames_done, n);
   endtask

   // Monitor: a rising busy marks a frame; every sample of it is checked against the queue head.
   initial begin : monitor
      exp_t e;
      logic bits [0:10];
      int   nbits, total, good, len;
      forever begin
         @(negedge clk);
         if (busy) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_frame", 1, 0);
               len = 0;
               while (busy && len < 5000) begin
                  @(negedge clk);
                  len++;
               end
            end else begin
               e = exp_q.pop_front();
               bits[0] = 1'b0;
               for (int i = 0; i < 8; i++) bits[i+1] = e.data[i];
               nbits = 9;
               if (e.par_en) begin
                  bits[9] = e.par_bit;
                  nbits = 10;
               end
               bits[nbits] = 1'b1;
               nbits++;
               total = (e.abort_at > 0) ? e.abort_at : nbits * e.p;
               for (int b = 0; b < nbits; b++) begin
                  if (b * e.p < total) begin
                     good = 0;
                     len  = 0;
                     for (int c = 0; c < e.p && (b * e.p + c) < total; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (busy && TX_OUT == bits[b]) good++;
                        len++;
                     end
                     checkOutput($sformatf("frame%0d_bit%0d_cycles_ok", frames_done, b), good, len);
                  end
               end
               @(negedge clk);
               checkOutput($sformatf("frame%0d_idle_busy", frames_done), int'(busy), 0);
               checkOutput($sformatf("frame%0d_idle_tx", frames_done), int'(TX_OUT), 1);
               frames_done++;
            end
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
      repeat (2) @(negedge clk);
      checkOutput("reset_tx", int'(TX_OUT), 1);
      checkOutput("reset_busy", int'(busy), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // No parity, 0xA5 at P=8
      applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8, 8, 1'b0, 0);
      waitFrames(1);

      // 0x37 has five ones: even parity bit 1, odd parity bit 0
      applyStimulus(8'h37, 1'b1, 1'b0, 6'd16, 16, 1'b1, 0);
      waitFrames(2);
      applyStimulus(8'h37, 1'b1, 1'b1, 6'd16, 16, 1'b0, 0);
      waitFrames(3);

      // Requests during a frame are ignored and the in-flight inputs are frozen
      applyStimulus(8'hFF, 1'b0, 1'b0, 6'd8, 8, 1'b0, 0);
      repeat (10) @(negedge clk);
      P_DATA = 8'h00; PAR_EN = 1'b1; Prescale = 6'd3; Data_Valid = 1'b1;
      repeat (20) @(negedge clk);
      Data_Valid = 1'b0;
      waitFrames(4);
      repeat (20) @(negedge clk);
      checkOutput("no_second_frame_queue", exp_q.size(), 0);
      checkOutput("no_second_frame_count", frames_done, 4);

      // Back-to-back with Data_Valid held high: one idle cycle between frames
      @(negedge clk);
      begin
         exp_t e1, e2;
         e1.data = 8'h3C; e1.par_en = 1'b0; e1.par_bit = 1'b0; e1.p = 8; e1.abort_at = 0;
         e2.data = 8'hC3; e2.par_en = 1'b0; e2.par_bit = 1'b0; e2.p = 8; e2.abort_at = 0;
         exp_q.push_back(e1);
         exp_q.push_back(e2);
      end
      P_DATA = 8'h3C; PAR_EN = 1'b0; Prescale = 6'd8; Data_Valid = 1'b1;
      @(negedge clk);
      P_DATA = 8'hC3;
      repeat (81) @(negedge clk);
      Data_Valid = 1'b0;
      waitFrames(6);

      // Prescale boundaries: 0 and 1 behave as 2, 63 is exact
      applyStimulus(8'h5A, 1'b0, 1'b0, 6'd0, 2, 1'b0, 0);
      waitFrames(7);
      applyStimulus(8'h81, 1'b1, 1'b0, 6'd1, 2, 1'b0, 0);
      waitFrames(8);
      applyStimulus(8'h96, 1'b1, 1'b1, 6'd63, 63, 1'b1, 0);
      waitFrames(9);

      // Reset during the 4th data bit (cycles 32..39 at P=8), with Data_Valid high under reset
      applyStimulus(8'h6B, 1'b0, 1'b0, 6'd8, 8, 1'b0, 35);
      repeat (34) @(negedge clk);
      rst = 1'b1; Data_Valid = 1'b1;
      @(negedge clk);
      rst = 1'b0; Data_Valid = 1'b0;
      waitFrames(10);
      repeat (3) @(negedge clk);
      applyStimulus(8'hD2, 1'b1, 1'b0, 6'd8, 8, 1'b0, 0);
      waitFrames(11);

      checkOutput("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
